// File: rtl/c_port_pipe_if.sv
// Operand-port bundle for c_port_pipe: enable, operand, valid, delayed outputs, fill status.
// Parity pins exist only when C_PORT_PIPE_PARITY_EN is defined.
interface c_port_pipe_if #(
    parameter int WIDTH = 48,
    parameter int IN_W  = 48
);
    logic             cec;
    logic [IN_W-1:0]  c;
    logic             c_vld;
    logic [WIDTH-1:0] c_out;
    logic             c_vld_out;
    logic             primed;
`ifdef C_PORT_PIPE_PARITY_EN
    logic             c_par;
    logic             perr;

    modport master (output cec, c, c_vld, c_par,
                    input  c_out, c_vld_out, primed, perr);
    modport slave  (input  cec, c, c_vld, c_par,
                    output c_out, c_vld_out, primed, perr);
`else
    modport master (output cec, c, c_vld,
                    input  c_out, c_vld_out, primed);
    modport slave  (input  cec, c, c_vld,
                    output c_out, c_vld_out, primed);
`endif
endinterface

// File: rtl/c_port_pipe.sv
// Sign-extending, clock-enabled operand pipeline of CREG stages with a saturating fill counter.
// Optional parity tracking and check is enabled by defining C_PORT_PIPE_PARITY_EN.
module c_port_pipe #(
    parameter int WIDTH = 48,
    parameter int IN_W  = 48,
    parameter int CREG  = 1
) (
    input  logic       clk,
    input  logic       rstc,
    c_port_pipe_if.slave bus
);
    logic [WIDTH-1:0] c_ext;
    logic [WIDTH-1:0] out_data;
    logic             out_vld;
    logic             out_primed;
`ifdef C_PORT_PIPE_PARITY_EN
    logic             out_par;
`endif

    // A sized cast of a signed operand sign-extends; with IN_W == WIDTH it is a plain copy.
    assign c_ext = WIDTH'($signed(bus.c));

    generate
        if (CREG == 0) begin : g_comb
            assign out_data   = c_ext;
            assign out_vld    = bus.c_vld;
            assign out_primed = 1'b1;
`ifdef C_PORT_PIPE_PARITY_EN
            assign out_par    = bus.c_par;
`endif
        end else begin : g_pipe
            localparam int CNT_W = (CREG > 1) ? $clog2(CREG + 1) : 1;
            localparam logic [CNT_W-1:0] FILL_MAX = CNT_W'(CREG);

            logic [WIDTH-1:0] data_q [CREG];
            logic [CREG-1:0]  vld_q;
            logic [CNT_W-1:0] fill_q;
`ifdef C_PORT_PIPE_PARITY_EN
            logic [CREG-1:0]  par_q;
`endif

            always_ff @(posedge clk) begin
                if (rstc) begin
                    for (int i = 0; i < CREG; i++) begin
                        data_q[i] <= '0;
                    end
                    vld_q  <= '0;
                    fill_q <= '0;
`ifdef C_PORT_PIPE_PARITY_EN
                    par_q  <= '0;
`endif
                end else if (bus.cec) begin
                    data_q[0] <= c_ext;
                    vld_q[0]  <= bus.c_vld;
`ifdef C_PORT_PIPE_PARITY_EN
                    par_q[0]  <= bus.c_par;
`endif
                    for (int i = 1; i < CREG; i++) begin
                        data_q[i] <= data_q[i-1];
                        vld_q[i]  <= vld_q[i-1];
`ifdef C_PORT_PIPE_PARITY_EN
                        par_q[i]  <= par_q[i-1];
`endif
                    end
                    // Saturate rather than wrap so PRIMED stays high once reached.
                    if (fill_q != FILL_MAX) begin
                        fill_q <= fill_q + 1'b1;
                    end
                end
            end

            assign out_data   = data_q[CREG-1];
            assign out_vld    = vld_q[CREG-1];
            assign out_primed = (fill_q == FILL_MAX);
`ifdef C_PORT_PIPE_PARITY_EN
            assign out_par    = par_q[CREG-1];
`endif
        end
    endgenerate

    assign bus.c_out     = out_data;
    assign bus.c_vld_out = out_vld;
    assign bus.primed    = out_primed;
`ifdef C_PORT_PIPE_PARITY_EN
    // Even parity: the operand bits together with the parity bit must XOR to zero.
    assign bus.perr      = out_vld & ((^out_data[IN_W-1:0]) ^ out_par);
`endif

endmodule

// File: tb/tb_c_port_pipe.sv
// Self-checking bench for c_port_pipe: five instances (depths 0..4, one narrow input)
// share one stimulus stream and are checked against a history-based reference model.
module tb_c_port_pipe;
    logic clk = 1'b0;
    logic rstc;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    c_port_pipe_if #(.WIDTH(48), .IN_W(48)) if0 ();
    c_port_pipe_if #(.WIDTH(48), .IN_W(18)) if1 ();
    c_port_pipe_if #(.WIDTH(48), .IN_W(48)) if2 ();
    c_port_pipe_if #(.WIDTH(48), .IN_W(48)) if3 ();
    c_port_pipe_if #(.WIDTH(48), .IN_W(48)) if4 ();

    c_port_pipe #(.WIDTH(48), .IN_W(48), .CREG(0)) u0 (.clk(clk), .rstc(rstc), .bus(if0));
    c_port_pipe #(.WIDTH(48), .IN_W(18), .CREG(1)) u1 (.clk(clk), .rstc(rstc), .bus(if1));
    c_port_pipe #(.WIDTH(48), .IN_W(48), .CREG(2)) u2 (.clk(clk), .rstc(rstc), .bus(if2));
    c_port_pipe #(.WIDTH(48), .IN_W(48), .CREG(3)) u3 (.clk(clk), .rstc(rstc), .bus(if3));
    c_port_pipe #(.WIDTH(48), .IN_W(48), .CREG(4)) u4 (.clk(clk), .rstc(rstc), .bus(if4));

    // Reference model: everything accepted on enabled, non-reset edges since the last reset.
    logic [47:0] h_c[$];
    bit          h_v[$];
    bit          h_p[$];
    bit          cur_cec;
    logic [47:0] cur_c;
    bit          cur_v;
    bit          cur_p;

    function automatic logic [47:0] mask_of(int w);
        logic [47:0] m;
        m = '0;
        for (int i = 0; i < w; i++) m[i] = 1'b1;
        return m;
    endfunction

    function automatic logic [47:0] ext(logic [47:0] raw, int w);
        logic [47:0] m;
        m = mask_of(w);
        if (raw[w-1]) return (raw & m) | ~m;
        return raw & m;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_dut(input string name, input int d, input int w,
                           input logic [47:0] od, input logic ov, input logic op, input logic operr);
        logic [47:0] raw;
        bit ev, ep, par;
        int n;
        n = h_c.size();
        if (d == 0) begin
            raw = cur_c; ev = cur_v; par = cur_p; ep = 1'b1;
        end else if (n >= d) begin
            raw = h_c[n-d]; ev = h_v[n-d]; par = h_p[n-d]; ep = 1'b1;
        end else begin
            raw = '0; ev = 1'b0; par = 1'b0; ep = 1'b0;
        end
        chk({name, ".c_out"},     64'(od), 64'(ext(raw, w)));
        chk({name, ".c_vld_out"}, 64'(ov), 64'(ev));
        chk({name, ".primed"},    64'(op), 64'(ep));
`ifdef C_PORT_PIPE_PARITY_EN
        chk({name, ".perr"}, 64'(operr), 64'(ev && ((^(raw & mask_of(w))) != par)));
`else
        if (operr !== 1'b0) chk({name, ".perr_absent"}, 64'(operr), 64'd0);
`endif
    endtask

    task automatic check_all();
        logic pe0, pe1, pe2, pe3, pe4;
`ifdef C_PORT_PIPE_PARITY_EN
        pe0 = if0.perr; pe1 = if1.perr; pe2 = if2.perr; pe3 = if3.perr; pe4 = if4.perr;
`else
        pe0 = 1'b0; pe1 = 1'b0; pe2 = 1'b0; pe3 = 1'b0; pe4 = 1'b0;
`endif
        chk_dut("u0", 0, 48, if0.c_out, if0.c_vld_out, if0.primed, pe0);
        chk_dut("u1", 1, 18, if1.c_out, if1.c_vld_out, if1.primed, pe1);
        chk_dut("u2", 2, 48, if2.c_out, if2.c_vld_out, if2.primed, pe2);
        chk_dut("u3", 3, 48, if3.c_out, if3.c_vld_out, if3.primed, pe3);
        chk_dut("u4", 4, 48, if4.c_out, if4.c_vld_out, if4.primed, pe4);
    endtask

    task automatic drive(input bit cen, input logic [47:0] cv, input bit v, input bit p);
        cur_cec = cen; cur_c = cv; cur_v = v; cur_p = p;
        if0.cec = cen; if0.c = cv;        if0.c_vld = v;
        if1.cec = cen; if1.c = cv[17:0];  if1.c_vld = v;
        if2.cec = cen; if2.c = cv;        if2.c_vld = v;
        if3.cec = cen; if3.c = cv;        if3.c_vld = v;
        if4.cec = cen; if4.c = cv;        if4.c_vld = v;
`ifdef C_PORT_PIPE_PARITY_EN
        if0.c_par = p; if1.c_par = p; if2.c_par = p; if3.c_par = p; if4.c_par = p;
`endif
    endtask

    task automatic step(input bit cen, input bit rs, input logic [47:0] cv, input bit v, input bit p);
        drive(cen, cv, v, p);
        rstc = rs;
        #1 check_all();
        @(posedge clk);
        if (rs) begin
            h_c.delete(); h_v.delete(); h_p.delete();
        end else if (cen) begin
            h_c.push_back(cv); h_v.push_back(v); h_p.push_back(p);
        end
        #1 check_all();
    endtask

    initial begin
        rstc = 1'b1;
        drive(1'b0, 48'd0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1 check_all();
        chk("reset.u4.c_out", 64'(if4.c_out), 64'd0);
        chk("reset.u2.primed", 64'(if2.primed), 64'd0);

        // Latency 2 on the depth-2 instance.
        step(1, 0, 48'h000000000123, 1, 0);
        chk("lat2.edge1.vld", 64'(if2.c_vld_out), 64'd0);
        chk("lat2.edge1.primed", 64'(if2.primed), 64'd0);
        step(1, 0, 48'd0, 0, 0);
        chk("lat2.edge2.c_out", 64'(if2.c_out), 64'h123);
        chk("lat2.edge2.vld", 64'(if2.c_vld_out), 64'd1);
        chk("lat2.edge2.primed", 64'(if2.primed), 64'd1);

        // Depth 3 with a four-cycle enable gap after the second value.
        step(0, 1, 48'd0, 0, 0);
        step(1, 0, 48'd1, 1, 0);
        step(1, 0, 48'd2, 1, 0);
        repeat (4) begin
            step(0, 0, {16'd0, $urandom}, 1'($urandom), 0);
            chk("gap.u3.c_out", 64'(if3.c_out), 64'd0);
            chk("gap.u3.primed", 64'(if3.primed), 64'd0);
        end
        step(1, 0, 48'd3, 1, 0);
        chk("gap.first", 64'(if3.c_out), 64'd1);
        step(1, 0, 48'd0, 0, 0);
        chk("gap.second", 64'(if3.c_out), 64'd2);
        step(1, 0, 48'd0, 0, 0);
        chk("gap.third", 64'(if3.c_out), 64'd3);
        chk("gap.third.vld", 64'(if3.c_vld_out), 64'd1);

        // Sign extension from 18 bits.
        step(1, 0, 48'h000000020000, 1, 0);
        chk("sext.neg", 64'(if1.c_out), 64'hFFFFFFFE0000);
        step(1, 0, 48'h00000001FFFF, 1, 0);
        chk("sext.pos", 64'(if1.c_out), 64'h00000001FFFF);

        // Reset with enable low clears a full depth-4 pipeline.
        repeat (5) step(1, 0, {16'd0, $urandom}, 1, 0);
        chk("full.u4.vld", 64'(if4.c_vld_out), 64'd1);
        step(0, 1, 48'h0000DEADBEEF, 1, 0);
        chk("rst_nocec.c_out", 64'(if4.c_out), 64'd0);
        chk("rst_nocec.vld", 64'(if4.c_vld_out), 64'd0);
        chk("rst_nocec.primed", 64'(if4.primed), 64'd0);

        // Depth 0 follows the input between edges.
        rstc = 1'b0;
        drive(0, 48'h000000000ABC, 1, 0);
        #1 chk("comb.a", 64'(if0.c_out), 64'h000000000ABC);
        drive(0, 48'h800000000000, 0, 0);
        #1 chk("comb.b", 64'(if0.c_out), 64'h800000000000);
        chk("comb.vld", 64'(if0.c_vld_out), 64'd0);
        chk("comb.primed", 64'(if0.primed), 64'd1);

`ifdef C_PORT_PIPE_PARITY_EN
        step(1, 0, 48'h3, 1, 1);
        chk("par.bad", 64'(if1.perr), 64'd1);
        step(1, 0, 48'h3, 1, 0);
        chk("par.good", 64'(if1.perr), 64'd0);
`endif

        // Random traffic.
        for (int k = 0; k < 400; k++) begin
            step(($urandom_range(0, 3) != 0), ($urandom_range(0, 39) == 0),
                 {16'($urandom), $urandom}, 1'($urandom), 1'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
